trail_collision_reader: RTL and testbench
=========================================

Name: trail_collision_reader

Overview:
- Read-side companion to the player trail writer: before a light-cycle head commits a move, this block checks the destination 8x8 cell against the arena walls and the trail RAM.
- It issues reads on a shared trail-RAM read port and returns a collision verdict to the player FSM.
- It reports whether the hit was a wall or a trail, and which trail code was hit (8'hFF = player 1, 8'h80 = player 2, 8'h00 = empty).
- It sits between the player controllers and the trail RAM's read port, alongside the VGA scan reader.

Parameters:
- H_RES, 640, pixels per line; RAM address = y*H_RES + x.
- CELL_W, 8, head cell width in pixels.
- CELL_H, 8, head cell height in pixels.
- MIN_X, 16, leftmost legal pixel column.
- MAX_X, 623, rightmost legal pixel column.
- MIN_Y, 16, top legal pixel row.
- MAX_Y, 463, bottom legal pixel row.
- RD_LATENCY, 2, cycles from granted read to valid rd_data (range 1..7).
- EMPTY_CODE, 8'h00, RAM value meaning "no trail".

Ports:
- VGA_CLK  input  1  sole clock, pixel clock domain.
- reset  input  1  asynchronous, active-high reset.
- req  input  1  start-check strobe; sampled only in IDLE.
- head_x  input  10  candidate cell top-left x, pixel coords.
- head_y  input  10  candidate cell top-left y, pixel coords.
- rd_en  output  1  read request to trail-RAM port.
- rd_addr  output  19  read address, valid while rd_en=1.
- rd_gnt  input  1  arbiter grant; the read is accepted in any cycle where rd_en=1 and rd_gnt=1.
- rd_data  input  8  RAM data, valid RD_LATENCY cycles after the accept cycle.
- busy  output  1  high from the cycle after req is accepted until DONE.
- done  output  1  one-cycle pulse; results valid.
- collision  output  1  result: cell blocked.
- hit_wall  output  1  result: blocked by arena bounds.
- hit_code  output  8  first non-empty trail value found, else 0.

Behaviour:
- Reset (async assert, sync release): state=IDLE; rd_en, rd_addr, busy, done, collision, hit_wall, hit_code all 0.
- States: IDLE, CHECK, ISSUE, WAIT, DONE.
- IDLE:
  - req=1 latches head_x/head_y, clears collision, hit_wall and hit_code, and goes to CHECK.
  - req while not IDLE is ignored (no queueing).
- CHECK (1 cycle):
  - Bounds are evaluated on the whole cell in 11-bit unsigned arithmetic: legal iff x>=MIN_X, x+CELL_W-1<=MAX_X, y>=MIN_Y, y+CELL_H-1<=MAX_Y.
  - Illegal: collision=1, hit_wall=1, no RAM access, go to DONE.
  - Legal: sample index k=0, go to ISSUE.
- Sample points, in order k=0..3: (x,y), (x+CELL_W-1,y), (x,y+CELL_H-1), (x+CELL_W-1,y+CELL_H-1).
- Address arithmetic: rd_addr=(y_k*H_RES+x_k), computed at 19 bits.
- ISSUE:
  - rd_en=1 with rd_addr stable.
  - rd_gnt=0: hold rd_en and rd_addr unchanged, remain in ISSUE.
  - rd_gnt=1: this is the accept cycle; go to WAIT with latency counter=RD_LATENCY; rd_en drops next cycle.
- WAIT:
  - rd_en=0; occupies exactly RD_LATENCY cycles.
  - rd_data is captured at the end of the last WAIT cycle.
  - If the captured value is not EMPTY_CODE: collision=1, hit_code=value, go to DONE (early exit).
  - Else if k=3, go to DONE.
  - Else k=k+1, go to ISSUE.
- DONE:
  - done=1 for one cycle; busy drops in the following cycle; return to IDLE.
  - collision, hit_wall and hit_code hold until the next req is accepted.
- Latency (rd_gnt tied high, RD_LATENCY=2, req accepted at cycle 0):
  - No hit: CHECK at cycle 1, samples occupy cycles 2..13, done at cycle 14.
  - Wall hit: done at cycle 2.
  - Hit on sample 0: done at cycle 5.
- Reset mid-operation: immediate return to IDLE with all outputs 0; any in-flight RAM data is discarded.
- req coincident with DONE: ignored; must be re-issued once in IDLE.

Test Plan:
- Reset then idle, rd_gnt=1, RAM all 0, req with head=(216,240) -> rd_addr sequence 153816, 153823, 158296, 158303; done at cycle 14; collision=0, hit_code=0.
- head=(8,240) -> no rd_en ever asserted; done at cycle 2; collision=1, hit_wall=1.
- head=(616,240) (cell right edge 623) -> legal, 4 reads; head=(624,240) -> wall hit.
- RAM[158303]=8'h80, head=(216,240) -> collision=1, hit_code=8'h80, hit_wall=0; exactly 4 accepts; done at cycle 14.
- RAM[153816]=8'hFF -> early exit, one accept only, done at cycle 5, hit_code=8'hFF.
- rd_gnt low for 3 cycles during ISSUE of k=1 -> rd_en and rd_addr=153823 held stable for 4 cycles, result unchanged, done delayed by 3 cycles.
- Assert reset during WAIT of k=2 -> all outputs 0 asynchronously; next req runs a full clean check.

Source files
------------

// File: rtl/trail_collision_reader.sv
// Collision probe for a candidate 8x8 head cell: arena-bound test, then up to four
// corner reads of the trail RAM through a shared, arbitrated read port.
//
// state  | meaning
// IDLE   | waiting for req; results from the last check held
// CHECK  | whole-cell bounds test on the latched head position
// ISSUE  | rd_en high for corner k until the arbiter grants
// WAIT   | counting down the RAM read latency; data taken on the last cycle
// DONE   | one-cycle done pulse, then back to IDLE
module trail_collision_reader #(
    parameter int          H_RES      = 640,
    parameter int          CELL_W     = 8,
    parameter int          CELL_H     = 8,
    parameter int          MIN_X      = 16,
    parameter int          MAX_X      = 623,
    parameter int          MIN_Y      = 16,
    parameter int          MAX_Y      = 463,
    parameter int          RD_LATENCY = 2,
    parameter logic [7:0]  EMPTY_CODE = 8'h00
) (
    input  logic        VGA_CLK,
    input  logic        reset,
    input  logic        req,
    input  logic [9:0]  head_x,
    input  logic [9:0]  head_y,
    output logic        rd_en,
    output logic [18:0] rd_addr,
    input  logic        rd_gnt,
    input  logic [7:0]  rd_data,
    output logic        busy,
    output logic        done,
    output logic        collision,
    output logic        hit_wall,
    output logic [7:0]  hit_code
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t      state, state_nxt;
    logic [9:0]  x_q, y_q;
    logic [1:0]  k_q;
    logic [2:0]  lat_cnt;

    logic [10:0] x_lo, x_hi, y_lo, y_hi;
    logic [10:0] samp_x, samp_y;
    logic [18:0] addr_k;
    logic        legal;
    logic        last_wait;
    logic        data_hit;

    assign x_lo = {1'b0, x_q};
    assign y_lo = {1'b0, y_q};
    assign x_hi = x_lo + 11'(CELL_W - 1);
    assign y_hi = y_lo + 11'(CELL_H - 1);
    assign legal = (x_lo >= 11'(MIN_X)) && (x_hi <= 11'(MAX_X)) &&
                   (y_lo >= 11'(MIN_Y)) && (y_hi <= 11'(MAX_Y));

    // k bit 0 selects right column, bit 1 selects bottom row
    assign samp_x = k_q[0] ? x_hi : x_lo;
    assign samp_y = k_q[1] ? y_hi : y_lo;
    assign addr_k = 19'(samp_y) * 19'(H_RES) + 19'(samp_x);

    assign last_wait = (lat_cnt == 3'd1);
    assign data_hit  = (rd_data != EMPTY_CODE);

    always_ff @(posedge VGA_CLK or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (req) state_nxt = S_CHECK;
            S_CHECK: state_nxt = legal ? S_ISSUE : S_DONE;
            S_ISSUE: if (rd_gnt) state_nxt = S_WAIT;
            S_WAIT: begin
                if (last_wait) begin
                    if (data_hit || (k_q == 2'd3)) state_nxt = S_DONE;
                    else                           state_nxt = S_ISSUE;
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        rd_en   = (state == S_ISSUE);
        rd_addr = rd_en ? addr_k : '0;
        busy    = (state != S_IDLE);
        done    = (state == S_DONE);
    end

    always_ff @(posedge VGA_CLK or posedge reset) begin
        if (reset) begin
            x_q       <= '0;
            y_q       <= '0;
            k_q       <= '0;
            lat_cnt   <= '0;
            collision <= 1'b0;
            hit_wall  <= 1'b0;
            hit_code  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req) begin
                        x_q       <= head_x;
                        y_q       <= head_y;
                        collision <= 1'b0;
                        hit_wall  <= 1'b0;
                        hit_code  <= '0;
                    end
                end
                S_CHECK: begin
                    k_q <= '0;
                    if (!legal) begin
                        collision <= 1'b1;
                        hit_wall  <= 1'b1;
                    end
                end
                S_ISSUE: begin
                    if (rd_gnt) lat_cnt <= 3'(RD_LATENCY);
                end
                S_WAIT: begin
                    lat_cnt <= lat_cnt - 3'd1;
                    if (last_wait) begin
                        if (data_hit) begin
                            collision <= 1'b1;
                            hit_code  <= rd_data;
                        end else begin
                            k_q <= k_q + 2'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_trail_collision_reader.sv
// Bench for trail_collision_reader: directed vector table, hand-written stall and
// reset sequences, then randomized heads/RAM/grants against a corner-scan model.
module tb_trail_collision_reader;

    localparam int RD_LATENCY = 2;

    logic        VGA_CLK = 1'b0;
    logic        reset;
    logic        req;
    logic [9:0]  head_x, head_y;
    logic        rd_en;
    logic [18:0] rd_addr;
    logic        rd_gnt;
    logic [7:0]  rd_data;
    logic        busy, done, collision, hit_wall;
    logic [7:0]  hit_code;

    trail_collision_reader #(.RD_LATENCY(RD_LATENCY)) dut (
        .VGA_CLK   (VGA_CLK),
        .reset     (reset),
        .req       (req),
        .head_x    (head_x),
        .head_y    (head_y),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .rd_gnt    (rd_gnt),
        .rd_data   (rd_data),
        .busy      (busy),
        .done      (done),
        .collision (collision),
        .hit_wall  (hit_wall),
        .hit_code  (hit_code)
    );

    always #5 VGA_CLK = ~VGA_CLK;

    int n_vec  = 0;
    int n_fail = 0;

    // Sparse trail RAM; the read pipe carries filler 8'h5A outside the valid slot
    logic [7:0] ram [int];
    logic [7:0] pipe [0:RD_LATENCY-1];
    int         acc_q[$];

    assign rd_data = pipe[RD_LATENCY-1];

    function automatic logic [7:0] ram_rd(input int a);
        return ram.exists(a) ? ram[a] : 8'h00;
    endfunction

    always @(posedge VGA_CLK or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < RD_LATENCY; i++) pipe[i] <= 8'h00;
        end else begin
            pipe[0] <= (rd_en && rd_gnt) ? ram_rd(int'(rd_addr)) : 8'h5A;
            for (int i = 1; i < RD_LATENCY; i++) pipe[i] <= pipe[i-1];
            if (rd_en && rd_gnt) acc_q.push_back(int'(rd_addr));
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Reference: bounds on the whole cell, then corners in fixed order until a non-empty hit
    bit         m_wall;
    int         m_addr[4];
    int         m_n;
    logic [7:0] m_code;

    task automatic model(input int x, input int y);
        int xs[4];
        int ys[4];
        xs = '{x, x + 7, x, x + 7};
        ys = '{y, y, y + 7, y + 7};
        m_wall = !(x >= 16 && x + 7 <= 623 && y >= 16 && y + 7 <= 463);
        m_code = 8'h00;
        m_n    = 0;
        for (int k = 0; k < 4; k++) begin
            m_addr[k] = ys[k] * 640 + xs[k];
            if (!m_wall && m_code == 8'h00) begin
                m_n    = k + 1;
                m_code = ram_rd(m_addr[k]);
            end
        end
    endtask

    // gnt_mode: 0 = always granted, 1 = random grants, 2 = hold off the 153823 read three times
    task automatic run_check(input int x, input int y, input int gnt_mode, input bit noise,
                             input int abort_at, output int dcyc, output int stalls,
                             output int k1_hold);
        int st;
        acc_q.delete();
        dcyc = -1; stalls = 0; k1_hold = 0; st = 0;
        @(negedge VGA_CLK);
        req    = 1'b1;
        head_x = 10'(x);
        head_y = 10'(y);
        rd_gnt = (gnt_mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
        for (int c = 1; c <= 200; c++) begin
            @(negedge VGA_CLK);
            req = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            if (noise) begin
                head_x = 10'($urandom_range(0, 1023));
                head_y = 10'($urandom_range(0, 1023));
            end
            if (c == 1) chk("busy_in_check", busy, 1);
            if (abort_at != 0 && acc_q.size() == abort_at) begin
                reset = 1'b1;
                #1;
                chk("rst_rd_en", rd_en, 0);
                chk("rst_rd_addr", rd_addr, 0);
                chk("rst_busy", busy, 0);
                chk("rst_done", done, 0);
                chk("rst_collision", collision, 0);
                chk("rst_hit_wall", hit_wall, 0);
                chk("rst_hit_code", hit_code, 0);
                @(negedge VGA_CLK);
                reset = 1'b0;
                dcyc  = 0;
                return;
            end
            if (done) begin
                dcyc = c;
                break;
            end
            if (rd_en && rd_addr == 19'd153823) k1_hold++;
            case (gnt_mode)
                1: rd_gnt = ($urandom_range(0, 3) != 0);
                2: begin
                    if (rd_en && rd_addr == 19'd153823 && st < 3) begin
                        rd_gnt = 1'b0;
                        st++;
                    end else begin
                        rd_gnt = 1'b1;
                    end
                end
                default: rd_gnt = 1'b1;
            endcase
            if (rd_en && !rd_gnt) stalls++;
        end
    endtask

    task automatic apply(input string tag, input int x, input int y, input int gnt_mode,
                         input bit noise, input logic ec, input logic ew, input logic [7:0] ecode,
                         input int eacc, input int edone);
        int dcyc, stalls, hold;
        model(x, y);
        run_check(x, y, gnt_mode, noise, 0, dcyc, stalls, hold);
        chk({tag, "_done_cycle"}, dcyc, edone + stalls);
        chk({tag, "_collision"}, collision, ec);
        chk({tag, "_hit_wall"}, hit_wall, ew);
        chk({tag, "_hit_code"}, hit_code, ecode);
        chk({tag, "_accepts"}, acc_q.size(), eacc);
        for (int i = 0; i < acc_q.size() && i < 4; i++)
            chk({tag, "_addr"}, acc_q[i], m_addr[i]);
        if (gnt_mode == 2) begin
            chk({tag, "_stalls"}, stalls, 3);
            chk({tag, "_k1_hold"}, hold, 4);
        end
        @(negedge VGA_CLK);
        req = 1'b0;
        chk({tag, "_done_pulse"}, done, 0);
        chk({tag, "_busy_drop"}, busy, 0);
        chk({tag, "_hold_collision"}, collision, ec);
        chk({tag, "_hold_code"}, hit_code, ecode);
    endtask

    typedef struct {
        int         x;
        int         y;
        int         ram_a;
        logic [7:0] ram_v;
        logic       ec;
        logic       ew;
        logic [7:0] ecode;
        int         eacc;
        int         edone;
    } vec_t;

    vec_t vecs[12];

    initial begin
        int dcyc, stalls, hold;
        vecs[0]  = '{216, 240,     -1, 8'h00, 1'b0, 1'b0, 8'h00, 4, 14};
        vecs[1]  = '{8,   240,     -1, 8'h00, 1'b1, 1'b1, 8'h00, 0, 2};
        vecs[2]  = '{616, 240,     -1, 8'h00, 1'b0, 1'b0, 8'h00, 4, 14};
        vecs[3]  = '{624, 240,     -1, 8'h00, 1'b1, 1'b1, 8'h00, 0, 2};
        vecs[4]  = '{216, 240, 158303, 8'h80, 1'b1, 1'b0, 8'h80, 4, 14};
        vecs[5]  = '{216, 240, 153816, 8'hFF, 1'b1, 1'b0, 8'hFF, 1, 5};
        vecs[6]  = '{16,  16,   14736, 8'hFF, 1'b1, 1'b0, 8'hFF, 3, 11};
        vecs[7]  = '{16,  15,      -1, 8'h00, 1'b1, 1'b1, 8'h00, 0, 2};
        vecs[8]  = '{15,  16,      -1, 8'h00, 1'b1, 1'b1, 8'h00, 0, 2};
        vecs[9]  = '{16,  456,     -1, 8'h00, 1'b0, 1'b0, 8'h00, 4, 14};
        vecs[10] = '{16,  457,     -1, 8'h00, 1'b1, 1'b1, 8'h00, 0, 2};
        vecs[11] = '{1023, 1023,   -1, 8'h00, 1'b1, 1'b1, 8'h00, 0, 2};

        reset  = 1'b1;
        req    = 1'b0;
        rd_gnt = 1'b1;
        head_x = '0;
        head_y = '0;
        repeat (3) @(negedge VGA_CLK);
        chk("reset_rd_en", rd_en, 0);
        chk("reset_rd_addr", rd_addr, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_collision", collision, 0);
        chk("reset_hit_wall", hit_wall, 0);
        chk("reset_hit_code", hit_code, 0);
        reset = 1'b0;
        repeat (2) @(negedge VGA_CLK);

        for (int i = 0; i < 12; i++) begin
            ram.delete();
            if (vecs[i].ram_a >= 0) ram[vecs[i].ram_a] = vecs[i].ram_v;
            apply($sformatf("vec%0d", i), vecs[i].x, vecs[i].y, 0, 1'b0,
                  vecs[i].ec, vecs[i].ew, vecs[i].ecode, vecs[i].eacc, vecs[i].edone);
        end

        // Grant withheld for three cycles on corner k=1
        ram.delete();
        apply("stall_k1", 216, 240, 2, 1'b0, 1'b0, 1'b0, 8'h00, 4, 14);

        // Reset while corner k=2's data is in flight; that data must never surface
        ram.delete();
        ram[158296] = 8'h80;
        run_check(216, 240, 0, 1'b0, 3, dcyc, stalls, hold);
        chk("abort_reached", dcyc, 0);
        ram.delete();
        apply("after_reset", 216, 240, 0, 1'b0, 1'b0, 1'b0, 8'h00, 4, 14);

        for (int r = 0; r < 40; r++) begin
            int x, y, nh;
            logic ec;
            x = $urandom_range(6, 632);
            y = $urandom_range(6, 472);
            ram.delete();
            model(x, y);
            nh = $urandom_range(0, 2);
            for (int h = 0; h < nh; h++) begin
                int k;
                k = $urandom_range(0, 3);
                if (m_addr[k] >= 0 && m_addr[k] < 307200)
                    ram[m_addr[k]] = ($urandom_range(0, 1) != 0) ? 8'hFF : 8'h80;
            end
            model(x, y);
            ec = m_wall || (m_code != 8'h00);
            apply($sformatf("rand%0d", r), x, y, 1, 1'($urandom_range(0, 1)),
                  ec, m_wall, m_wall ? 8'h00 : m_code, m_n,
                  m_wall ? 2 : 2 + 3 * m_n);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
